hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage RV64I core. Sits beside the decode stage and keeps its own shadow copy of the destination-register state for the E, M and W stages. From that copy it produces:
- stall and flush controls for the IF/ID and ID/EX registers,
- operand-forwarding selects for execute,
- register-file bypass selects for decode.

It also keeps saturating counters of stall and flush cycles for performance debug.

## Interface
- CNT_W, 32, width of the stall/flush performance counters
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- Valid_D  in  1  IF/ID register holds a real instruction
- Rs1_D  in  5  rs1 index of the decode instruction
- Rs2_D  in  5  rs2 index of the decode instruction
- Rd_D  in  5  rd index of the decode instruction
- Use_rs1_D  in  1  decode instruction reads rs1
- Use_rs2_D  in  1  decode instruction reads rs2
- RegWrite_D  in  1  decode instruction writes rd
- ResultSrc_D  in  2  writeback source; 2'b01 = load
- PCSrc_E  in  1  branch/jump taken, resolved in execute
- Stall_F  out  1  hold PC
- Stall_D  out  1  hold IF/ID register
- Flush_D  out  1  clear IF/ID register
- Flush_E  out  1  clear ID/EX register (insert bubble)
- ForwardA_E  out  2  execute operand A source
- ForwardB_E  out  2  execute operand B source
- Fwd1_D  out  1  decode RD1 must take Result_W (same-cycle write-through)
- Fwd2_D  out  1  decode RD2 must take Result_W
- StallCnt  out  CNT_W  cycles with Stall_D asserted, saturating
- FlushCnt  out  CNT_W  cycles with PCSrc_E asserted, saturating

Forward codes: 2'b00 = register value, 2'b10 = ALUResult_M, 2'b01 = Result_W.

## Operation
- Shadow slots E, M, W. Each slot holds:
  - v: slot will write a register, i.e. writer valid with rd != 0
  - rd
  - ld: instruction is a load
  - rs1 and rs2: with use flags, held in E only
- A register index of 0 never matches anything and never forwards.
- Load-use hazard (lu):
  - E.v, and E.ld, and Valid_D
  - and either Use_rs1_D with Rs1_D == E.rd, or Use_rs2_D with Rs2_D == E.rd.
- Stall_F = Stall_D = lu & !PCSrc_E. A taken branch overrides the stall, because the decode instruction is discarded anyway.
- Flush_D = PCSrc_E.
- Flush_E = lu | PCSrc_E.
- ForwardA_E, evaluated in priority order:
  1. 10 if E.use1, and E.rs1 != 0, and M.v, and M.rd == E.rs1;
  2. else 01 if W.v and W.rd == E.rs1;
  3. else 00.
- ForwardB_E is the same rule applied to rs2.
- M outranks W because it holds the younger writer.
- Fwd1_D = Valid_D & Use_rs1_D & Rs1_D != 0 & W.v & W.rd == Rs1_D. Fwd2_D follows the same rule for rs2.

Slot advance, every cycle:
- W <= M.
- M <= E. E always advances; the instruction causing PCSrc_E proceeds to M.
- E <= bubble (all fields 0) if Flush_E.
- Otherwise E <= decode fields, with:
  - v = Valid_D & RegWrite_D & Rd_D != 0,
  - ld = (ResultSrc_D == 2'b01).
- Decode-side stall state is not stored here; the IF/ID register holds itself.

Counters:
- StallCnt increments when Stall_D = 1.
- FlushCnt increments when PCSrc_E = 1.
- Both hold at all-ones.

## Timing
- Reset (rst low, asynchronous): all slot fields 0 and both counters 0.
  - Therefore every output is 0 during and immediately after reset.
  - Deassertion takes effect at the first rising edge with rst high.
- All hazard and forward outputs are combinational from the slots and the D inputs, with zero latency. No combinational path from PCSrc_E reaches the Forward outputs.
- Load-use penalty is exactly one cycle:
  - cycle n: Stall_D = 1 and a bubble enters E;
  - cycle n+1: the load is in M, so lu = 0 and the consumer forwards from W (code 01) the following cycle.
- Branch penalty: Flush_D and Flush_E assert in the same cycle as PCSrc_E, squashing two younger instructions.
- Simultaneous lu and PCSrc_E: flush wins. Stall_F = Stall_D = 0, Flush_D = Flush_E = 1.
- Back-to-back writers of the same rd in M and W: M wins.
- Reset asserted mid-stall clears the slots immediately, so Stall_D drops asynchronously.
- Counter saturation: at all-ones a further event leaves the value unchanged.

## Test plan
- Reset: hold rst low for 3 cycles with random inputs. All outputs read 0. Release. StallCnt = FlushCnt = 0.
- Load-use:
  - `ld x5` followed by `add x6,x5,x7` (Use_rs1_D=1): exactly one cycle of Stall_F = Stall_D = Flush_E = 1.
  - Next cycle: stall clear.
  - One cycle later: ForwardA_E = 01.
  - StallCnt = 1.
- ALU chain: `add x5`, `sub x6,x5,x5`, `or x7,x5,x6`.
  - sub in E: ForwardA_E = ForwardB_E = 10.
  - or in E: ForwardA_E = 01 (x5 from W) and ForwardB_E = 10 (x6 from M).
  - No stalls.
- x0 and unused operand:
  - `ld x0` followed by a use of x0: no stall.
  - `ld x5` followed by `addi x6,x8,1` with Rs2_D field = 5 and Use_rs2_D = 0: no stall.
- Branch priority: load-use condition and PCSrc_E = 1 in the same cycle.
  - Required: Stall_D = 0, Flush_D = Flush_E = 1.
  - Next cycle: E is a bubble and all forwards are 00.
  - FlushCnt = 1.
- Write-through and saturation:
  - W.rd = 9 valid while decode reads rs2 = 9: Fwd2_D = 1, Fwd1_D = 0.
  - With CNT_W = 4: 20 consecutive stalls leave StallCnt = 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV64I core: shadow E/M/W writer slots drive stall, flush and forwarding selects.
// Latency: all hazard/forward outputs are combinational (zero cycles); slots and counters update on each rising clk edge.
// Backpressure: Stall_F/Stall_D hold fetch and decode on a load-use hazard; a taken branch (PCSrc_E) overrides the stall and flushes.
//
// Ports:
//   clk, rst (async, active-low)
//   Valid_D, Rs1_D, Rs2_D, Rd_D, Use_rs1_D, Use_rs2_D, RegWrite_D, ResultSrc_D : decode instruction fields
//   PCSrc_E                                   : branch/jump taken, resolved in execute
//   Stall_F, Stall_D, Flush_D, Flush_E        : pipeline register controls
//   ForwardA_E, ForwardB_E                    : execute operand source (00 reg, 10 ALUResult_M, 01 Result_W)
//   Fwd1_D, Fwd2_D                            : decode read ports take Result_W (write-through)
//   StallCnt, FlushCnt                        : saturating performance counters
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid_D,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rd_D,
  input  logic             Use_rs1_D,
  input  logic             Use_rs2_D,
  input  logic             RegWrite_D,
  input  logic [1:0]       ResultSrc_D,
  input  logic             PCSrc_E,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             Fwd1_D,
  output logic             Fwd2_D,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] SRC_LD  = 2'b01;

  // E slot keeps the source operands so execute forwarding needs no extra
  // pipeline plumbing. M and W only need the writer identity: the load
  // flag matters solely while the load sits in E.
  logic       e_v;
  logic       e_ld;
  logic       e_use1;
  logic       e_use2;
  logic [4:0] e_rd;
  logic [4:0] e_rs1;
  logic [4:0] e_rs2;
  logic       m_v;
  logic [4:0] m_rd;
  logic       w_v;
  logic [4:0] w_rd;

  logic       lu;

  // *_v already implies rd != 0, so x0 can never match a writer slot.
  assign lu = e_v & e_ld & Valid_D &
              ((Use_rs1_D & (Rs1_D == e_rd)) | (Use_rs2_D & (Rs2_D == e_rd)));

  assign Stall_F = lu & ~PCSrc_E;
  assign Stall_D = lu & ~PCSrc_E;

  // Flushes are gated by rst so every output reads 0 while reset is held,
  // even if a stray PCSrc_E arrives from a not-yet-reset execute stage.
  assign Flush_D = PCSrc_E & rst;
  assign Flush_E = (lu | PCSrc_E) & rst;

  // M is checked first: it holds the younger writer of the same register.
  function automatic logic [1:0] fwd_sel(
    input logic       use_src,
    input logic [4:0] rs,
    input logic       mv,
    input logic [4:0] mrd,
    input logic       wv,
    input logic [4:0] wrd
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (use_src && (rs != 5'd0) && mv && (mrd == rs)) begin
      sel = FWD_M;
    end else if (wv && (wrd == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  // Forward selects depend on slot state only, keeping PCSrc_E off this path.
  assign ForwardA_E = fwd_sel(e_use1, e_rs1, m_v, m_rd, w_v, w_rd);
  assign ForwardB_E = fwd_sel(e_use2, e_rs2, m_v, m_rd, w_v, w_rd);

  // Register file is written at the end of W; decode reads in the same
  // cycle, so it takes Result_W directly.
  assign Fwd1_D = Valid_D & Use_rs1_D & (Rs1_D != 5'd0) & w_v & (w_rd == Rs1_D);
  assign Fwd2_D = Valid_D & Use_rs2_D & (Rs2_D != 5'd0) & w_v & (w_rd == Rs2_D);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_v    <= 1'b0;
      e_ld   <= 1'b0;
      e_use1 <= 1'b0;
      e_use2 <= 1'b0;
      e_rd   <= 5'd0;
      e_rs1  <= 5'd0;
      e_rs2  <= 5'd0;
      m_v    <= 1'b0;
      m_rd   <= 5'd0;
      w_v    <= 1'b0;
      w_rd   <= 5'd0;
    end else begin
      w_v  <= m_v;
      w_rd <= m_rd;
      // E always advances, including the branch that raised PCSrc_E.
      m_v  <= e_v;
      m_rd <= e_rd;
      if (Flush_E) begin
        e_v    <= 1'b0;
        e_ld   <= 1'b0;
        e_use1 <= 1'b0;
        e_use2 <= 1'b0;
        e_rd   <= 5'd0;
        e_rs1  <= 5'd0;
        e_rs2  <= 5'd0;
      end else begin
        e_v    <= Valid_D & RegWrite_D & (Rd_D != 5'd0);
        e_ld   <= (ResultSrc_D == SRC_LD);
        e_use1 <= Use_rs1_D;
        e_use2 <= Use_rs2_D;
        e_rd   <= Rd_D;
        e_rs1  <= Rs1_D;
        e_rs2  <= Rs2_D;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (Stall_D && (StallCnt != '1)) begin
        StallCnt <= StallCnt + CNT_W'(1);
      end
      if (PCSrc_E && (FlushCnt != '1)) begin
        FlushCnt <= FlushCnt + CNT_W'(1);
      end
    end
  end

endmodule
